host_arbiter: RTL

HOST_ARBITER -- requirements
Module: host_arbiter

---
 rtl/host_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/host_arbiter.sv
// host_arbiter: two-requester, round-robin arbiter onto a single host bus.
// One access is in flight at a time. The winner's request is latched, driven
// on the host bus until host_ack or a TIMEOUT-cycle wait expires, then a
// one-cycle ack (with read data and error flag) goes back to that requester.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   mN_req/wr/addr/wdata      access request from requester N (N = 0, 1)
//   mN_ack/rdata/err          one-cycle completion pulse with its read data and timeout flag
//   host_req/wr/addr/wdata    shared host bus command, driven only while in ISSUE
//   host_ack, host_rdata      host bus response, sampled only while in ISSUE
//   busy                      high whenever the arbiter is not IDLE
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// ISSUE | host_req held high; waits for host_ack or the timeout
// RESP  | one-cycle ack to the granted requester

module host_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              host_req,
    output logic              host_wr,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_wdata,
    input  logic              host_ack,
    input  logic [DATA_W-1:0] host_rdata,
    output logic              busy
);

    // Wait counter is at least 8 bits, wider only if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q,  last_d;
    logic              gnt_q,   gnt_d;
    logic              wr_q,    wr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the requester not granted last wins; otherwise
                    // the lone requester wins (m1_req alone selects 1).
                    gnt_d   = (m0_req && m1_req) ? ~last_q : m1_req;
                    last_d  = gnt_d;
                    wr_d    = gnt_d ? m1_wr    : m0_wr;
                    addr_d  = gnt_d ? m1_addr  : m0_addr;
                    wdata_d = gnt_d ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // host_ack is checked first so it wins over a same-cycle timeout.
                if (host_ack) begin
                    rdata_d = wr_q ? '0 : host_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // The host bus is only driven during ISSUE so it reads as all-zero otherwise.
    assign host_req   = (state_q == ST_ISSUE);
    assign host_wr    = host_req & wr_q;
    assign host_addr  = host_req ? addr_q  : '0;
    assign host_wdata = host_req ? wdata_q : '0;

    assign m0_ack   = (state_q == ST_RESP) && !gnt_q;
    assign m1_ack   = (state_q == ST_RESP) &&  gnt_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;
    assign m0_err   = m0_ack & err_q;
    assign m1_err   = m1_ack & err_q;

    assign busy = (state_q != ST_IDLE);

endmodule
